// File: rtl/spi_flash_sequencer_if.sv
// ----------------------------------------------------------------------------
// spi_flash_sequencer_if
//   Bundles the signals between qspi_sync, the flash sequencer and the
//   downstream output mux / logging logic.
//
//   From qspi_sync (into the sequencer):
//     spi_cs          synchronized !CS, 1 = bus deselected
//     spi_cmd_strobe  one-cycle pulse, first byte of a transaction on spi_byte
//     spi_byte_strobe one-cycle pulse, subsequent byte on spi_byte
//     spi_byte        received byte
//     status_in       value returned for RDSR (0x05)
//   From the sequencer (to mux / logger):
//     tx_byte         byte the FPGA shifts out when output_sel == 0
//     output_sel      0 = FPGA, 1 = ram0, 2 = ram1
//     spi_do_enable   pad output enables toward the PCH
//     cur_addr        current byte address
//     busy            sequencer not idle
//     event_strobe    one-cycle log pulse
//     event_cmd       command of the logged transaction
//     event_addr      start address of the logged transaction
// ----------------------------------------------------------------------------
interface spi_flash_sequencer_if;
    logic        spi_cs;
    logic        spi_cmd_strobe;
    logic        spi_byte_strobe;
    logic [7:0]  spi_byte;
    logic [7:0]  status_in;

    logic [7:0]  tx_byte;
    logic [1:0]  output_sel;
    logic [3:0]  spi_do_enable;
    logic [23:0] cur_addr;
    logic        busy;
    logic        event_strobe;
    logic [7:0]  event_cmd;
    logic [23:0] event_addr;

    // Sequencer side
    modport slave (
        input  spi_cs, spi_cmd_strobe, spi_byte_strobe, spi_byte, status_in,
        output tx_byte, output_sel, spi_do_enable, cur_addr, busy,
               event_strobe, event_cmd, event_addr
    );

    // Byte-stream source / observer side
    modport master (
        output spi_cs, spi_cmd_strobe, spi_byte_strobe, spi_byte, status_in,
        input  tx_byte, output_sel, spi_do_enable, cur_addr, busy,
               event_strobe, event_cmd, event_addr
    );
endinterface

// File: rtl/spi_flash_sequencer.sv
// ----------------------------------------------------------------------------
// spi_flash_sequencer
//   Decodes the SPI flash command stream delivered by qspi_sync and sequences
//   the spy datapath: selects the source of each byte returned to the PCH
//   (FPGA, ram0 or ram1), drives the pad output enables, tracks the current
//   flash address and emits one log event per transaction.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    spi_flash_sequencer_if.slave (byte stream in, datapath control out)
//
//   Parameters:
//     BANK_BIT    address bit selecting ram1 (1) or ram0 (0)
//     JEDEC_ID    bytes returned for 0x9F, MSB first
//     FAST_DUMMY  dummy bytes after the address for 0x0B (0..255)
// ----------------------------------------------------------------------------
module spi_flash_sequencer #(
    parameter int          BANK_BIT   = 23,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter int          FAST_DUMMY = 1
) (
    input logic                  clk,
    input logic                  reset,
    spi_flash_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DUMMY,
        DATA,
        ID,
        STAT,
        PASS
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_RDID  = 8'h9F;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [3:0] DO_EN_IO1 = 4'b0010;
    localparam logic [7:0] DUMMY_LAST = 8'((FAST_DUMMY > 0) ? FAST_DUMMY - 1 : 0);

    state_t      state;
    logic [7:0]  cmd_q;
    logic [1:0]  addr_cnt;
    logic [7:0]  dummy_cnt;
    logic [1:0]  id_cnt;
    logic        bank_q;
    logic        crossed_q;

    logic [7:0]  tx_byte_q;
    logic [1:0]  output_sel_q;
    logic [3:0]  do_en_q;
    logic [23:0] cur_addr_q;
    logic        busy_q;
    logic        event_strobe_q;
    logic [7:0]  event_cmd_q;
    logic [23:0] event_addr_q;

    logic [23:0] shifted_addr;
    logic [23:0] next_addr;

    // Address byte arrives MSB first; the 24-bit increment wraps naturally.
    assign shifted_addr = {cur_addr_q[15:0], bus.spi_byte};
    assign next_addr    = cur_addr_q + 24'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cmd_q          <= 8'h00;
            addr_cnt       <= 2'd0;
            dummy_cnt      <= 8'd0;
            id_cnt         <= 2'd0;
            bank_q         <= 1'b0;
            crossed_q      <= 1'b0;
            tx_byte_q      <= 8'hFF;
            output_sel_q   <= 2'd0;
            do_en_q        <= 4'd0;
            cur_addr_q     <= 24'd0;
            busy_q         <= 1'b0;
            event_strobe_q <= 1'b0;
            event_cmd_q    <= 8'h00;
            event_addr_q   <= 24'd0;
        end else begin
            event_strobe_q <= 1'b0;

            if (bus.spi_cs) begin
                // Deselect wins over any strobe in the same cycle and returns
                // every output to its idle value.
                state        <= IDLE;
                cmd_q        <= 8'h00;
                addr_cnt     <= 2'd0;
                dummy_cnt    <= 8'd0;
                id_cnt       <= 2'd0;
                bank_q       <= 1'b0;
                crossed_q    <= 1'b0;
                tx_byte_q    <= 8'hFF;
                output_sel_q <= 2'd0;
                do_en_q      <= 4'd0;
                cur_addr_q   <= 24'd0;
                busy_q       <= 1'b0;
                event_cmd_q  <= 8'h00;
                event_addr_q <= 24'd0;
            end else if (bus.spi_cmd_strobe) begin
                // A command byte restarts decode from any state.
                cmd_q        <= bus.spi_byte;
                addr_cnt     <= 2'd0;
                dummy_cnt    <= 8'd0;
                id_cnt       <= 2'd0;
                crossed_q    <= 1'b0;
                busy_q       <= 1'b1;
                output_sel_q <= 2'd0;
                case (bus.spi_byte)
                    CMD_READ, CMD_FAST: begin
                        state     <= ADDR;
                        tx_byte_q <= 8'hFF;
                        do_en_q   <= 4'd0;
                    end
                    CMD_RDID: begin
                        state          <= ID;
                        tx_byte_q      <= JEDEC_ID[23:16];
                        do_en_q        <= DO_EN_IO1;
                        event_strobe_q <= 1'b1;
                        event_cmd_q    <= bus.spi_byte;
                        event_addr_q   <= 24'd0;
                    end
                    CMD_RDSR: begin
                        state          <= STAT;
                        tx_byte_q      <= bus.status_in;
                        do_en_q        <= DO_EN_IO1;
                        event_strobe_q <= 1'b1;
                        event_cmd_q    <= bus.spi_byte;
                        event_addr_q   <= 24'd0;
                    end
                    default: begin
                        state          <= PASS;
                        tx_byte_q      <= 8'hFF;
                        do_en_q        <= 4'd0;
                        event_strobe_q <= 1'b1;
                        event_cmd_q    <= bus.spi_byte;
                        event_addr_q   <= 24'd0;
                    end
                endcase
            end else if (bus.spi_byte_strobe) begin
                case (state)
                    ADDR: begin
                        cur_addr_q <= shifted_addr;
                        addr_cnt   <= addr_cnt + 2'd1;
                        if (addr_cnt == 2'd2) begin
                            event_strobe_q <= 1'b1;
                            event_cmd_q    <= cmd_q;
                            event_addr_q   <= shifted_addr;
                            if (cmd_q == CMD_FAST && FAST_DUMMY > 0) begin
                                state <= DUMMY;
                            end else begin
                                // Bank is fixed at the start address for the
                                // whole burst.
                                state        <= DATA;
                                bank_q       <= shifted_addr[BANK_BIT];
                                output_sel_q <= shifted_addr[BANK_BIT] ? 2'd2 : 2'd1;
                                do_en_q      <= DO_EN_IO1;
                            end
                        end
                    end
                    DUMMY: begin
                        dummy_cnt <= dummy_cnt + 8'd1;
                        if (dummy_cnt == DUMMY_LAST) begin
                            state        <= DATA;
                            bank_q       <= cur_addr_q[BANK_BIT];
                            output_sel_q <= cur_addr_q[BANK_BIT] ? 2'd2 : 2'd1;
                            do_en_q      <= DO_EN_IO1;
                        end
                    end
                    DATA: begin
                        cur_addr_q <= next_addr;
                        // Leaving the latched bank hands the bus back to the
                        // FPGA for the rest of the burst, even if it wraps back.
                        if (crossed_q || (next_addr[BANK_BIT] != bank_q)) begin
                            crossed_q    <= 1'b1;
                            output_sel_q <= 2'd0;
                            tx_byte_q    <= 8'hFF;
                        end
                    end
                    ID: begin
                        case (id_cnt)
                            2'd0:    tx_byte_q <= JEDEC_ID[15:8];
                            2'd1:    tx_byte_q <= JEDEC_ID[7:0];
                            default: tx_byte_q <= 8'h00;
                        endcase
                        if (id_cnt != 2'd3) begin
                            id_cnt <= id_cnt + 2'd1;
                        end
                    end
                    STAT: begin
                        tx_byte_q <= bus.status_in;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.tx_byte       = tx_byte_q;
    assign bus.output_sel    = output_sel_q;
    assign bus.spi_do_enable = do_en_q;
    assign bus.cur_addr      = cur_addr_q;
    assign bus.busy          = busy_q;
    assign bus.event_strobe  = event_strobe_q;
    assign bus.event_cmd     = event_cmd_q;
    assign bus.event_addr    = event_addr_q;

endmodule
